// File: rtl/la_operand_ctrl.sv
// la_operand_ctrl
//   Logic-analyzer driven operand loader and result reader for a
//   processing core. Software writes commands through a 128-bit LA word.
//   A command is taken when the strobe bit toggles. Operands are assembled
//   chunk by chunk and pushed to the core. The last operand also becomes
//   the serial key. The core result is then read back chunk by chunk.
//
// Ports
//   wb_clk_i        sole clock, rising edge
//   wb_rst_i        asynchronous active-high reset
//   la_data_in      command: [127:120] opcode, [119:112] index,
//                   [111] strobe toggle, [CHUNK_W-1:0] payload
//   la_oenb         unused
//   la_data_out     status: [127:120] state, [119:112] operands loaded,
//                   [111] ack toggle, [110] sticky error,
//                   [CHUNK_W-1:0] read payload
//   master_ena_proc core run enable (PROC only)
//   load_data       one-cycle operand push strobe
//   load_status     index of the operand being pushed
//   data_out        pushed operand, zero when load_data is low
//   ki              current key bit (PROC only)
//   next_key        advance key by one bit
//   slv_done        core finished
//   data_in         core result
module la_operand_ctrl #(
  parameter  int OP_W    = 163,
  parameter  int CHUNK_W = 82,
  parameter  int N_OPS   = 6,
  parameter  int TIMEOUT = 65535,
  localparam int NCH     = (OP_W + CHUNK_W - 1) / CHUNK_W,
  localparam int IW      = (N_OPS > 1) ? $clog2(N_OPS) : 1
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [127:0]    la_data_in,
  input  logic [127:0]    la_oenb,
  output logic [127:0]    la_data_out,
  output logic            master_ena_proc,
  output logic            load_data,
  output logic [IW-1:0]   load_status,
  output logic [OP_W-1:0] data_out,
  output logic            ki,
  input  logic            next_key,
  input  logic            slv_done,
  input  logic [OP_W-1:0] data_in
);

  localparam int NW = NCH * CHUNK_W;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [7:0] OPC_START  = 8'h30;
  localparam logic [7:0] OPC_WCHUNK = 8'h31;
  localparam logic [7:0] OPC_RUN    = 8'h41;
  localparam logic [7:0] OPC_RCHUNK = 8'h50;
  localparam logic [7:0] OPC_RDONE  = 8'h5F;
  localparam logic [7:0] OPC_CLRERR = 8'hEE;
  localparam logic [7:0] OPC_ABORT  = 8'hFF;

  typedef enum logic [7:0] {
    S_IDLE  = 8'h00,
    S_WRITE = 8'h01,
    S_PROC  = 8'h02,
    S_READ  = 8'h03
  } state_t;

  state_t               state;
  logic                 strobe_q, ack_q, err_q;
  logic [7:0]           op_cnt;
  logic [NCH-1:0]       mask;
  logic [NW-1:0]        asm_buf;
  logic [OP_W-1:0]      key_q, result_q;
  logic [CHUNK_W-1:0]   rd_payload;
  logic [TW-1:0]        proc_cnt;

  logic [7:0]           opcode, idx;
  logic [CHUNK_W-1:0]   payload;
  logic                 cmd_valid, abort, cmd_err, cmd_ok, push, timeout_hit;
  logic [NCH-1:0]       wr_sel;
  logic [NW-1:0]        res_ext;
  logic [CHUNK_W-1:0]   res_chunk;
  logic                 unused_bits;

  assign opcode    = la_data_in[127:120];
  assign idx       = la_data_in[119:112];
  assign payload   = la_data_in[CHUNK_W-1:0];
  assign cmd_valid = la_data_in[111] ^ strobe_q;
  assign abort     = cmd_valid && (opcode == OPC_ABORT);
  // A completed operand is pushed on the cycle after its last chunk lands.
  assign push      = (state == S_WRITE) && (&mask);
  assign timeout_hit = (TIMEOUT != 0) && (proc_cnt == TW'(TIMEOUT - 1));
  assign unused_bits = ^{la_oenb, la_data_in[110:CHUNK_W], asm_buf};

  // Chunk select for both buffer writes and result reads. An index with no
  // matching chunk leaves wr_sel empty, which flags it as out of range.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    res_ext             = '0;
    res_ext[OP_W-1:0]   = result_q;
    res_chunk           = '0;
    wr_sel              = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx == 8'(i)) begin
        res_chunk = res_ext[i*CHUNK_W +: CHUNK_W];
        wr_sel[i] = 1'b1;
      end
    end
  end

  // Legality of the accepted command in the current state.
  always_comb begin
    cmd_err = 1'b0;
    if (cmd_valid && !abort) begin
      case (state)
        S_IDLE:  cmd_err = !(opcode == OPC_START || opcode == OPC_CLRERR);
        S_WRITE: begin
          if (opcode == OPC_WCHUNK)
            // A push in flight for the last operand already fills the job.
            cmd_err = !(|wr_sel) || (op_cnt == 8'(N_OPS)) ||
                      (push && op_cnt == 8'(N_OPS - 1));
          else if (opcode == OPC_RUN)
            cmd_err = (op_cnt != 8'(N_OPS));
          else
            cmd_err = 1'b1;
        end
        S_READ: begin
          if (opcode == OPC_RCHUNK)     cmd_err = !(|wr_sel);
          else if (opcode == OPC_RDONE) cmd_err = 1'b0;
          else                          cmd_err = 1'b1;
        end
        default: cmd_err = 1'b1;
      endcase
    end
  end

  assign cmd_ok = cmd_valid && !abort && !cmd_err;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      // NOTE: the wide assembly, key and result registers are reset too, so nothing from a previous job leaks into the next.
      state       <= S_IDLE;
      strobe_q    <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      op_cnt      <= '0;
      mask        <= '0;
      asm_buf     <= '0;
      key_q       <= '0;
      result_q    <= '0;
      rd_payload  <= '0;
      proc_cnt    <= '0;
      load_data   <= 1'b0;
      load_status <= '0;
      data_out    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read sees pre-edge state.
      strobe_q    <= la_data_in[111];
      load_data   <= 1'b0;
      load_status <= '0;
      data_out    <= '0;
      if (cmd_valid) ack_q <= la_data_in[111];
      if (cmd_err)   err_q <= 1'b1;

      if (abort) begin
        state      <= S_IDLE;
        op_cnt     <= '0;
        mask       <= '0;
        proc_cnt   <= '0;
        rd_payload <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_ok && opcode == OPC_START) begin
              state   <= S_WRITE;
              op_cnt  <= '0;
              mask    <= '0;
              asm_buf <= '0;
            end else if (cmd_ok && opcode == OPC_CLRERR) begin
              err_q <= 1'b0;
            end
          end

          S_WRITE: begin
            if (push) begin
              load_data   <= 1'b1;
              load_status <= op_cnt[IW-1:0];
              data_out    <= asm_buf[OP_W-1:0];
              op_cnt      <= op_cnt + 8'd1;
              if (op_cnt == 8'(N_OPS - 1)) key_q <= asm_buf[OP_W-1:0];
            end
            if (cmd_ok && opcode == OPC_WCHUNK) begin
              for (int i = 0; i < NCH; i++)
                if (wr_sel[i]) asm_buf[i*CHUNK_W +: CHUNK_W] <= payload;
              mask <= (push ? '0 : mask) | wr_sel;
            end else if (push) begin
              mask <= '0;
            end
            if (cmd_ok && opcode == OPC_RUN) begin
              state    <= S_PROC;
              proc_cnt <= '0;
            end
          end

          S_PROC: begin
            if (next_key) key_q <= {1'b0, key_q[OP_W-1:1]};
            if (timeout_hit) begin
              state    <= S_IDLE;
              err_q    <= 1'b1;
              proc_cnt <= '0;
            end else if (slv_done) begin
              state    <= S_READ;
              result_q <= data_in;
            end else begin
              proc_cnt <= proc_cnt + 1'b1;
            end
          end

          S_READ: begin
            if (cmd_ok && opcode == OPC_RCHUNK) begin
              rd_payload <= res_chunk;
            end else if (cmd_ok && opcode == OPC_RDONE) begin
              state      <= S_IDLE;
              rd_payload <= '0;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign master_ena_proc = (state == S_PROC);
  assign ki              = (state == S_PROC) && key_q[0];

  always_comb begin
    la_data_out                = '0;
    la_data_out[127:120]       = state;
    la_data_out[119:112]       = op_cnt;
    la_data_out[111]           = ack_q;
    la_data_out[110]           = err_q;
    la_data_out[CHUNK_W-1:0]   = rd_payload;
  end

endmodule
